// File: rtl/axi_xbar_aw_w_sched.sv
// Write-path scheduler for one crossbar master port: round-robin AW arbitration plus in-order W steering.
// Define AXI_XBAR_SCHED_W_BYPASS_EN to let W follow an AW in its own handshake cycle when no W is queued.
module axi_xbar_aw_w_sched #(
  parameter int unsigned NoSlvPorts = 4,
  parameter int unsigned MaxWTrans  = 8,
  parameter int unsigned AwWidth    = 64,
  localparam int unsigned IdxW = (NoSlvPorts == 1) ? 1 : $clog2(NoSlvPorts),
  localparam int unsigned CntW = $clog2(MaxWTrans + 1)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NoSlvPorts-1:0]                slv_aw_valid_i,
  input  logic [NoSlvPorts-1:0][AwWidth-1:0]   slv_aw_i,
  output logic [NoSlvPorts-1:0]                slv_aw_ready_o,
  output logic                                 mst_aw_valid_o,
  output logic [AwWidth-1:0]                   mst_aw_o,
  output logic [IdxW-1:0]                      mst_aw_sel_o,
  input  logic                                 mst_aw_ready_i,
  input  logic [NoSlvPorts-1:0]                slv_w_valid_i,
  input  logic [NoSlvPorts-1:0]                slv_w_last_i,
  output logic [NoSlvPorts-1:0]                slv_w_ready_o,
  output logic                                 mst_w_valid_o,
  output logic                                 mst_w_last_o,
  output logic [IdxW-1:0]                      mst_w_sel_o,
  input  logic                                 mst_w_ready_i,
  output logic [CntW-1:0]                      w_outstanding_o
);

  localparam int unsigned PtrW = (MaxWTrans == 1) ? 1 : $clog2(MaxWTrans);

  logic [IdxW-1:0] rr_q;
  logic            lock_q;
  logic [IdxW-1:0] sel_q;
  logic [IdxW-1:0] fifo_q [MaxWTrans];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;

  logic            arb_found;
  logic [IdxW-1:0] arb_idx, cand;
  logic [IdxW-1:0] grant;
  logic            grant_vld, fifo_full, fifo_empty, aw_hs;
  logic            w_active, w_last_hs, push, pop;
  logic [IdxW-1:0] w_idx;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxWTrans - 1)) ? '0 : p + 1'b1;
  endfunction

  // First requesting input at or after the round-robin pointer, wrapping around.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int k = 0; k < int'(NoSlvPorts); k++) begin
      cand = IdxW'((int'(rr_q) + k) % int'(NoSlvPorts));
      if (!arb_found && slv_aw_valid_i[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // A stalled grant is held in sel_q so a later higher-priority request cannot preempt it.
  assign grant      = lock_q ? sel_q : arb_idx;
  assign grant_vld  = (lock_q | arb_found) & ~rst_i;
  assign fifo_full  = (cnt_q == CntW'(MaxWTrans));
  assign fifo_empty = (cnt_q == '0);

  assign mst_aw_valid_o = grant_vld & ~fifo_full;
  assign aw_hs          = mst_aw_valid_o & mst_aw_ready_i;
  assign mst_aw_o       = slv_aw_i[grant];
  assign mst_aw_sel_o   = rst_i ? '0 : grant;

  always_comb begin
    slv_aw_ready_o = '0;
    if (aw_hs) slv_aw_ready_o[grant] = 1'b1;
  end

  always_comb begin
    w_active = 1'b0;
    w_idx    = '0;
    if (!fifo_empty) begin
      w_active = 1'b1;
      w_idx    = fifo_q[rd_ptr_q];
    end
`ifdef AXI_XBAR_SCHED_W_BYPASS_EN
    else if (aw_hs) begin
      w_active = 1'b1;
      w_idx    = grant;
    end
`endif
  end

  assign mst_w_sel_o   = w_idx;
  assign mst_w_valid_o = w_active & slv_w_valid_i[w_idx];
  assign mst_w_last_o  = w_active & slv_w_last_i[w_idx];

  always_comb begin
    slv_w_ready_o = '0;
    if (w_active) slv_w_ready_o[w_idx] = mst_w_ready_i;
  end

  // A burst that completes through the bypass never needs a FIFO entry.
  assign w_last_hs = mst_w_valid_o & mst_w_ready_i & mst_w_last_o;
  assign pop       = w_last_hs & ~fifo_empty;
  assign push      = aw_hs & ~(fifo_empty & w_last_hs);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q     <= '0;
      lock_q   <= 1'b0;
      sel_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(MaxWTrans); i++) fifo_q[i] <= '0;
    end else begin
      if (aw_hs) begin
        rr_q   <= (grant == IdxW'(NoSlvPorts - 1)) ? '0 : grant + 1'b1;
        lock_q <= 1'b0;
      end else if (mst_aw_valid_o) begin
        lock_q <= 1'b1;
        sel_q  <= grant;
      end
      if (push) begin
        fifo_q[wr_ptr_q] <= grant;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_q + CntW'(push) - CntW'(pop);
    end
  end

  assign w_outstanding_o = cnt_q;

endmodule

// File: tb/tb_axi_xbar_aw_w_sched.sv
// Scoreboard bench for axi_xbar_aw_w_sched: a queue-based model predicts each cycle, a monitor compares.
// Directed scenarios cover reset, round-robin, grant hold, full, W ordering and push/pop; then random traffic.
module tb_axi_xbar_aw_w_sched;

  localparam int N  = 4;
  localparam int D  = 8;
  localparam int AW = 64;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         slv_aw_valid;
  logic [N-1:0][AW-1:0] slv_aw;
  logic [N-1:0]         slv_aw_ready;
  logic                 mst_aw_valid;
  logic [AW-1:0]        mst_aw;
  logic [1:0]           mst_aw_sel;
  logic                 mst_aw_ready;
  logic [N-1:0]         slv_w_valid;
  logic [N-1:0]         slv_w_last;
  logic [N-1:0]         slv_w_ready;
  logic                 mst_w_valid;
  logic                 mst_w_last;
  logic [1:0]           mst_w_sel;
  logic                 mst_w_ready;
  logic [3:0]           w_outstanding;

  axi_xbar_aw_w_sched #(.NoSlvPorts(N), .MaxWTrans(D), .AwWidth(AW)) dut (
    .clk_i(clk), .rst_i(rst),
    .slv_aw_valid_i(slv_aw_valid), .slv_aw_i(slv_aw), .slv_aw_ready_o(slv_aw_ready),
    .mst_aw_valid_o(mst_aw_valid), .mst_aw_o(mst_aw), .mst_aw_sel_o(mst_aw_sel),
    .mst_aw_ready_i(mst_aw_ready),
    .slv_w_valid_i(slv_w_valid), .slv_w_last_i(slv_w_last), .slv_w_ready_o(slv_w_ready),
    .mst_w_valid_o(mst_w_valid), .mst_w_last_o(mst_w_last), .mst_w_sel_o(mst_w_sel),
    .mst_w_ready_i(mst_w_ready), .w_outstanding_o(w_outstanding)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic          aw_v;
    logic [1:0]    aw_sel;
    logic [AW-1:0] aw_data;
    logic [N-1:0]  aw_rdy;
    logic          w_v;
    logic [1:0]    w_sel;
    logic          chk_last;
    logic          w_last;
    logic [N-1:0]  w_rdy;
    logic [3:0]    cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests_run = 0;
  int   tests_failed = 0;
  bit   rand_payload = 1'b0;

  // Reference model: outstanding bursts as a queue of input indices in AW order.
  int   m_q[$];
  int   m_rr;
  bit   m_lock;
  int   m_lidx;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] awv, input logic awr,
                               input logic [N-1:0] wv, input logic [N-1:0] wl, input logic wr);
    exp_t e;
    int   g, h;
    bit   has_g, aw_v, aw_hs, w_act, w_hs, was_empty;
    @(posedge clk);
    #1;
    slv_aw_valid = awv;
    mst_aw_ready = awr;
    slv_w_valid  = wv;
    slv_w_last   = wl;
    mst_w_ready  = wr;
    for (int i = 0; i < N; i++)
      slv_aw[i] = rand_payload ? {$urandom, $urandom} : {32'hA000_0000 + i, 32'h0000_5A5A * (i + 1)};
    has_g = 0;
    g = 0;
    if (m_lock) begin
      has_g = 1;
      g = m_lidx;
    end else begin
      for (int k = 0; k < N; k++)
        if (!has_g && awv[(m_rr + k) % N]) begin
          has_g = 1;
          g = (m_rr + k) % N;
        end
    end
    aw_v  = has_g && (m_q.size() < D);
    aw_hs = aw_v && awr;
    was_empty = (m_q.size() == 0);
    w_act = 0;
    h = 0;
    if (!was_empty) begin
      w_act = 1;
      h = m_q[0];
    end
`ifdef AXI_XBAR_SCHED_W_BYPASS_EN
    else if (aw_hs) begin
      w_act = 1;
      h = g;
    end
`endif
    w_hs = w_act && wv[h] && wr;
    e.aw_v     = aw_v;
    e.aw_sel   = 2'(g);
    e.aw_data  = slv_aw[g];
    e.aw_rdy   = aw_hs ? 4'(1 << g) : 4'd0;
    e.w_v      = w_act && wv[h];
    e.w_sel    = 2'(h);
    e.chk_last = w_act;
    e.w_last   = wl[h];
    e.w_rdy    = (w_act && wr) ? 4'(1 << h) : 4'd0;
    e.cnt      = 4'(m_q.size());
    exp_q.push_back(e);
    if (w_hs && wl[h] && !was_empty) m_q.delete(0);
    if (aw_hs && !(was_empty && w_hs && wl[h])) m_q.push_back(g);
    if (aw_hs) begin
      m_rr = (g + 1) % N;
      m_lock = 0;
    end else if (aw_v) begin
      m_lock = 1;
      m_lidx = g;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * D && m_q.size() > 0; i++) applyStimulus('0, 1'b0, '1, '1, 1'b1);
    checkOutput("drain_empty", 64'(m_q.size()), 64'd0);
  endtask

  // Reset with every AW input requesting; outputs must stay quiet while reset is held.
  task automatic resetDut();
    @(posedge clk);
    #1;
    rst = 1'b1;
    slv_aw_valid = '1;
    mst_aw_ready = 1'b1;
    slv_w_valid = '1;
    slv_w_last = '1;
    mst_w_ready = 1'b1;
    @(negedge clk);
    checkOutput("rst_aw_valid", 64'(mst_aw_valid), 64'd0);
    checkOutput("rst_aw_ready", 64'(slv_aw_ready), 64'd0);
    checkOutput("rst_w_valid", 64'(mst_w_valid), 64'd0);
    checkOutput("rst_w_ready", 64'(slv_w_ready), 64'd0);
    checkOutput("rst_outstanding", 64'(w_outstanding), 64'd0);
    @(posedge clk);
    #1;
    slv_aw_valid = '0;
    slv_w_valid = '0;
    slv_w_last = '0;
    rst = 1'b0;
    m_q.delete();
    m_rr = 0;
    m_lock = 0;
    m_lidx = 0;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checkOutput("aw_valid", 64'(mst_aw_valid), 64'(mon_e.aw_v));
      if (mon_e.aw_v) begin
        checkOutput("aw_sel", 64'(mst_aw_sel), 64'(mon_e.aw_sel));
        checkOutput("aw_payload", mst_aw, mon_e.aw_data);
      end
      checkOutput("aw_ready", 64'(slv_aw_ready), 64'(mon_e.aw_rdy));
      checkOutput("w_valid", 64'(mst_w_valid), 64'(mon_e.w_v));
      checkOutput("w_sel", 64'(mst_w_sel), 64'(mon_e.w_sel));
      if (mon_e.chk_last) checkOutput("w_last", 64'(mst_w_last), 64'(mon_e.w_last));
      checkOutput("w_ready", 64'(slv_w_ready), 64'(mon_e.w_rdy));
      checkOutput("outstanding", 64'(w_outstanding), 64'(mon_e.cnt));
    end
  end

  initial begin
    int rr_seq[9] = '{0, 1, 2, 3, 0, 2, 3, 0, 2};
    rst = 1'b1;
    slv_aw_valid = '0;
    slv_aw = '0;
    mst_aw_ready = 1'b0;
    slv_w_valid = '0;
    slv_w_last = '0;
    mst_w_ready = 1'b0;
    resetDut();

    // Round-robin: all inputs, then input 1 dropped; single-beat W drains behind.
    for (int i = 0; i < 9; i++) begin
      applyStimulus((i < 5) ? 4'b1111 : 4'b1101, 1'b1, 4'hf, 4'hf, 1'b1);
      @(negedge clk);
      checkOutput("rr_sequence", 64'(mst_aw_sel), 64'(rr_seq[i]));
    end

    // Grant hold: input 2 stalls, input 1 joins, grant must not move.
    applyStimulus(4'b0100, 1'b0, 4'hf, 4'hf, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0110, 1'b0, 4'hf, 4'hf, 1'b1);
      @(negedge clk);
      checkOutput("hold_sel", 64'(mst_aw_sel), 64'd2);
      checkOutput("hold_payload", mst_aw, {32'hA000_0002, 32'h0001_0F0E});
    end
    applyStimulus(4'b0110, 1'b1, 4'hf, 4'hf, 1'b1);
    applyStimulus(4'b0010, 1'b1, 4'hf, 4'hf, 1'b1);
    @(negedge clk);
    checkOutput("after_hold_sel", 64'(mst_aw_sel), 64'd1);
    drain();

    // Full: eight AWs with W withheld, then one burst completes.
    for (int i = 0; i < D; i++) applyStimulus(4'hf, 1'b1, 4'h0, 4'h0, 1'b0);
    applyStimulus(4'hf, 1'b1, 4'h0, 4'h0, 1'b0);
    @(negedge clk);
    checkOutput("full_outstanding", 64'(w_outstanding), 64'd8);
    checkOutput("full_aw_valid", 64'(mst_aw_valid), 64'd0);
    applyStimulus(4'hf, 1'b1, 4'hf, 4'hf, 1'b1);
    applyStimulus(4'hf, 1'b1, 4'h0, 4'h0, 1'b0);
    @(negedge clk);
    checkOutput("unfull_outstanding", 64'(w_outstanding), 64'd7);
    checkOutput("unfull_aw_valid", 64'(mst_aw_valid), 64'd1);
    drain();

    // W ordering: AW from 3 (4 beats) then from 1 (2 beats); input 1 W is offered early.
    applyStimulus(4'b1000, 1'b1, 4'b0010, 4'b0000, 1'b1);
    applyStimulus(4'b0010, 1'b1, 4'b0010, 4'b0000, 1'b1);
    for (int b = 0; b < 4; b++) begin
      applyStimulus(4'b0000, 1'b0, 4'b1010, (b == 3) ? 4'b1000 : 4'b0000, 1'b1);
      @(negedge clk);
      checkOutput("order_sel3", 64'(mst_w_sel), 64'd3);
      checkOutput("order_block1", 64'(slv_w_ready[1]), 64'd0);
    end
    for (int b = 0; b < 2; b++) begin
      applyStimulus(4'b0000, 1'b0, 4'b0010, (b == 1) ? 4'b0010 : 4'b0000, 1'b1);
      @(negedge clk);
      checkOutput("order_sel1", 64'(mst_w_sel), 64'd1);
    end

    // Simultaneous push and pop with one entry outstanding.
    applyStimulus(4'b0001, 1'b1, 4'b0000, 4'b0000, 1'b0);
    applyStimulus(4'b0100, 1'b1, 4'b0001, 4'b0001, 1'b1);
    applyStimulus(4'b0000, 1'b0, 4'b0100, 4'b0000, 1'b0);
    @(negedge clk);
    checkOutput("pushpop_outstanding", 64'(w_outstanding), 64'd1);
    checkOutput("pushpop_head", 64'(mst_w_sel), 64'd2);
    drain();

`ifdef AXI_XBAR_SCHED_W_BYPASS_EN
    applyStimulus(4'b0001, 1'b1, 4'b0001, 4'b0001, 1'b1);
    @(negedge clk);
    checkOutput("bypass_w_valid", 64'(mst_w_valid), 64'd1);
    checkOutput("bypass_w_ready", 64'(slv_w_ready), 64'd1);
    applyStimulus(4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    checkOutput("bypass_outstanding", 64'(w_outstanding), 64'd0);
`endif

    // Random traffic, with a reset dropped into the middle of it.
    rand_payload = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] wl;
      for (int i = 0; i < N; i++) wl[i] = ($urandom_range(0, 2) == 0);
      applyStimulus(4'($urandom), ($urandom_range(0, 3) != 0), 4'($urandom), wl,
                    ($urandom_range(0, 3) != 0));
      if (c == 1500) resetDut();
    end
    drain();

    @(negedge clk);
    @(negedge clk);
    checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
